// File: rtl/game_judge.sv
// game_judge: walks the eight tic-tac-toe lines over a 1-cycle-latency board
// read port and reports win/draw status.
module game_judge #(
  parameter int ADDR_W = 4,
  parameter int CELL_W = 2
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [CELL_W-1:0] rdData,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              busy,
  output logic              done,
  output logic              gameIsDone,
  output logic [1:0]        winner
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  // read k lives at index k; three consecutive reads form one line
  localparam logic [23:0][ADDR_W-1:0] SEQ = {
    4'd6, 4'd4, 4'd2, 4'd8, 4'd4, 4'd0, 4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1,
    4'd6, 4'd3, 4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [1:0]        pos_q, pos_d;
  logic [CELL_W-1:0] c0_q, c0_d, c1_q, c1_d;
  logic              empty_q, empty_d, gd_q, gd_d;
  logic [1:0]        win_q, win_d;
  logic              cap, line_win;
  assign cap        = (state_q == SCAN) && (idx_q != 5'd0);
  assign line_win   = (c0_q == c1_q) && (c1_q == rdData) && rdData[1];
  assign rdAddr     = (state_q == SCAN && idx_q < 5'd24) ? SEQ[idx_q] : '0;
  assign busy       = state_q == SCAN;
  assign done       = state_q == DONE;
  assign gameIsDone = gd_q;
  assign winner     = win_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    empty_d = empty_q;
    gd_d    = gd_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        idx_d   = '0;
        pos_d   = '0;
        empty_d = 1'b0;
        gd_d    = 1'b0;
        win_d   = 2'b00;
      end
      SCAN: begin
        idx_d = idx_q + 5'd1;
        if (cap) begin
          empty_d = empty_q | ~rdData[1];
          pos_d   = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
          c0_d    = (pos_q == 2'd0) ? rdData : c0_q;
          c1_d    = (pos_q == 2'd1) ? rdData : c1_q;
          if (pos_q == 2'd2 && line_win) begin
            state_d = DONE;
            gd_d    = 1'b1;
            win_d   = rdData[1:0];
          end else if (pos_q == 2'd2 && idx_q == 5'd24) begin
            state_d = DONE;
            gd_d    = ~empty_d;
            win_d   = empty_d ? 2'b00 : 2'b01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      gd_d    = 1'b0;
      win_d   = 2'b00;
    end
  end
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      empty_q <= 1'b0;
      gd_q    <= 1'b0;
      win_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      empty_q <= empty_d;
      gd_q    <= gd_d;
      win_q   <= win_d;
    end
  end
endmodule

// File: tb/tb_game_judge.sv
// tb_game_judge: directed vector table plus hand-written clear/reset sequences.
module tb_game_judge;
  logic       ph1 = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0;
  logic [1:0] rdData = 2'b00;
  logic [3:0] rdAddr;
  logic       busy, done, gameIsDone;
  logic [1:0] winner;
  logic [1:0] mem [16];
  int checks = 0, errors = 0, bad_addr = 0;
  int seq [24];

  game_judge #(.ADDR_W(4), .CELL_W(2)) dut (
    .ph1(ph1), .reset(reset), .start(start), .clear(clear), .rdData(rdData),
    .rdAddr(rdAddr), .busy(busy), .done(done), .gameIsDone(gameIsDone), .winner(winner));

  always #5 ph1 = ~ph1;
  always @(posedge ph1) rdData <= mem[rdAddr];
  always @(negedge ph1) if (rdAddr > 4'd8) bad_addr++;

  typedef struct {
    logic [17:0] b;
    int          cyc;
    logic        gd;
    logic [1:0]  w;
  } vec_t;
  vec_t tv [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] mk(input string s);
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) begin
      byte c = s[i];
      b[2*i +: 2] = (c == "X") ? 2'b10 : (c == "O") ? 2'b11 : (c == "1") ? 2'b01 : 2'b00;
    end
    return b;
  endfunction

  task automatic load(input logic [17:0] b);
    for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? b[2*i +: 2] : 2'b00;
  endtask

  task automatic run(input int n, input vec_t v);
    int cyc, dc, nb, seq_err;
    logic gdd;
    logic [1:0] wd;
    int alog [24];
    load(v.b);
    @(negedge ph1); start = 1'b1;
    @(negedge ph1); start = 1'b0;
    cyc = 1; dc = 0; nb = 0; gdd = 1'b0; wd = 2'b00;
    chk($sformatf("v%0d_gd_cleared_at_start", n), gameIsDone, 0);
    while (dc == 0 && cyc < 40) begin
      if (done) begin
        dc = cyc; gdd = gameIsDone; wd = winner;
      end else if (busy) begin
        if (nb < 24) alog[nb] = rdAddr;
        nb++;
      end
      @(negedge ph1); cyc++;
    end
    seq_err = 0;
    for (int i = 0; i < 24; i++) if (i < nb && alog[i] != seq[i]) seq_err++;
    chk($sformatf("v%0d_done_cycle", n), dc, v.cyc);
    chk($sformatf("v%0d_gameIsDone", n), gdd, v.gd);
    chk($sformatf("v%0d_winner", n), wd, v.w);
    chk($sformatf("v%0d_busy_cycles", n), nb, v.cyc - 1);
    chk($sformatf("v%0d_addr_seq_errs", n), seq_err, 0);
    chk($sformatf("v%0d_done_one_cycle", n), done, 0);
    chk($sformatf("v%0d_result_held", n), {gameIsDone, winner}, {v.gd, v.w});
  endtask

  initial begin
    int busy_cnt, ev;
    seq = '{0,1,2,3,4,5,6,7,8,0,3,6,1,4,7,2,5,8,0,4,8,2,4,6};
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    tv[0] = '{mk("XXX......"),  5, 1'b1, 2'b10};
    tv[1] = '{mk("........."), 26, 1'b0, 2'b00};
    tv[2] = '{mk("XXO.O.OX."), 26, 1'b1, 2'b11};
    tv[3] = '{mk("XOXXOOOXX"), 26, 1'b1, 2'b01};
    tv[4] = '{mk("...OOO..."),  8, 1'b1, 2'b11};
    tv[5] = '{mk("..X..X..X"), 20, 1'b1, 2'b10};
    tv[6] = '{mk("X...X...X"), 23, 1'b1, 2'b10};
    tv[7] = '{mk("111......"), 26, 1'b0, 2'b00};
    tv[8] = '{mk("XOXXOOOX1"), 26, 1'b0, 2'b00};

    #2;
    chk("reset_outputs", {rdAddr, busy, done, gameIsDone, winner}, 0);
    @(negedge ph1); reset = 1'b0;

    for (int i = 0; i < 9; i++) run(i, tv[i]);

    // clear in IDLE wipes a held win verdict
    run(9, tv[0]);
    @(negedge ph1); clear = 1'b1;
    @(negedge ph1); clear = 1'b0;
    chk("clear_idle_verdict", {gameIsDone, winner}, 0);

    // clear at cycle 10 of a scan, start held high meanwhile
    run(10, tv[0]);
    load(mk("........."));
    @(negedge ph1); start = 1'b1;
    busy_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge ph1);
      if (busy && !done) busy_cnt++;
      if (c == 10) begin clear = 1'b1; start = 1'b0; end
    end
    chk("held_start_scan_busy", busy_cnt, 10);
    @(negedge ph1); clear = 1'b0;
    chk("clear_abort_outputs", {busy, done, gameIsDone, winner}, 0);
    ev = 0;
    for (int c = 0; c < 30; c++) begin @(negedge ph1); if (done || busy) ev++; end
    chk("clear_abort_no_done", ev, 0);

    // async reset at cycle 12
    @(negedge ph1); start = 1'b1;
    @(negedge ph1); start = 1'b0;
    for (int c = 1; c < 12; c++) @(negedge ph1);
    chk("pre_reset_addr", rdAddr, seq[11]);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {rdAddr, busy, done, gameIsDone, winner}, 0);
    @(negedge ph1); reset = 1'b0;
    ev = 0;
    for (int c = 0; c < 30; c++) begin @(negedge ph1); if (done || busy) ev++; end
    chk("reset_abort_no_done", ev, 0);

    // start and clear together in IDLE
    @(negedge ph1); start = 1'b1; clear = 1'b1;
    @(negedge ph1); start = 1'b0; clear = 1'b0;
    ev = 0;
    for (int c = 0; c < 5; c++) begin if (busy || done) ev++; @(negedge ph1); end
    chk("start_clear_stays_idle", ev, 0);

    chk("rdaddr_never_above_8", bad_addr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
